// File: rtl/led_counter_if.sv
// LED output bundle for the led_counter demo block.
// The counter drives the LED value through the master modport; the board
// pins (or a bench) observe it through the slave modport.
`timescale 1ns/1ps
interface led_counter_if;
  logic [7:0] leds;

  modport master (output leds);
  modport slave  (input  leds);
endinterface

// File: rtl/led_counter.sv
// Free-running 8-bit LED counter.
// A clock-cycle prescaler produces a one-cycle tick every HALF_PERIOD edges;
// each tick advances the LED value by one, wrapping 8'hFF -> 8'h00.
// Both the prescaler and the LED value clear asynchronously on rst, so a
// reset mid-count always restarts from a full period.
`timescale 1ns/1ps
module led_counter #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  led_counter_if.master led_bus
);

  localparam int HALF_PERIOD = CLK_FREQ / 2;
  localparam int DIV_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] prescaler;
  logic [DIV_W-1:0] prescaler_nxt;
  logic [7:0]       leds_q;
  logic [7:0]       leds_nxt;
  logic             tick;

  // Next-state: tick on the last prescaler count, restart the prescaler and
  // bump the LED value on that same edge; otherwise just advance the prescaler.
  always_comb begin
    tick          = 1'b0;
    prescaler_nxt = prescaler + DIV_ONE;
    leds_nxt      = leds_q;
    if (prescaler == DIV_LAST) begin
      tick          = 1'b1;
      prescaler_nxt = '0;
      leds_nxt      = leds_q + 8'd1;
    end
  end

  // State registers: asynchronous clear of both prescaler and LED value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      leds_q    <= 8'd0;
    end else begin
      prescaler <= prescaler_nxt;
      leds_q    <= leds_nxt;
    end
  end

  assign led_bus.leds = leds_q;

endmodule

// File: tb/tb_led_counter.sv
// Directed bench for led_counter with CLK_FREQ=10 (tick every 5 edges).
// Inputs are driven on the falling edge; leds is sampled on the falling edge
// (or shortly after an asynchronous reset, before the next rising edge).
`timescale 1ns/1ps
module tb_led_counter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  led_counter_if bus ();

  led_counter #(.CLK_FREQ(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .led_bus (bus.master)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  typedef struct {
    bit         do_reset;  // one-cycle reset pulse before running
    int         cycles;    // rising edges to run afterwards
    logic [7:0] exp_leds;  // expected leds afterwards
    string      name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: leds=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One-cycle synchronous-looking reset pulse, aligned to falling edges.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;

    vecs[0] = '{1'b1,  0, 8'd0,  "reset_state"};
    vecs[1] = '{1'b0, 15, 8'd3,  "run15"};
    vecs[2] = '{1'b1,  5, 8'd1,  "rst_run5"};
    vecs[3] = '{1'b1, 10, 8'd2,  "midreset_run10"};
    vecs[4] = '{1'b0, 40, 8'd10, "continue40"};
    vecs[5] = '{1'b0,  4, 8'd10, "no_tick_4"};
    vecs[6] = '{1'b0,  1, 8'd11, "tick_5th"};
    vecs[7] = '{1'b1,  4, 8'd0,  "rst_run4_no_tick"};
    vecs[8] = '{1'b0,  1, 8'd1,  "first_tick"};
    vecs[9] = '{1'b1,  9, 8'd1,  "rst_run9"};

    run(2);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_reset) pulse_reset();
      run(vecs[i].cycles);
      check(vecs[i].name, bus.leds, vecs[i].exp_leds);
    end

    // Asynchronous reset asserted between edges clears leds before any edge.
    pulse_reset();
    run(12);
    check("pre_async", bus.leds, 8'd2);
    #0.5 rst = 1'b1;
    #0.1 check("async_immediate", bus.leds, 8'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("async_hold", bus.leds, 8'd0);
    end
    rst = 1'b0;
    run(5);
    check("after_async_release", bus.leds, 8'd1);

    // Full wrap after 256 ticks.
    pulse_reset();
    run(256 * 5);
    check("wrap_full", bus.leds, 8'd0);

    // FE -> FF -> 00 on successive ticks.
    pulse_reset();
    run(254 * 5 - 1);
    check("pre_fe", bus.leds, 8'hFD);
    run(1);
    check("at_fe", bus.leds, 8'hFE);
    run(5);
    check("at_ff", bus.leds, 8'hFF);
    run(4);
    check("hold_ff", bus.leds, 8'hFF);
    run(1);
    check("wrap_00", bus.leds, 8'h00);

    // Tick spacing: leds equals edges/5 after every single edge.
    pulse_reset();
    for (int c = 1; c <= 30; c++) begin
      run(1);
      check("spacing", bus.leds, 8'(c / 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
